// File: rtl/flp_mul_arb_pkg.sv
// Shared types and width helpers for the FP multiplier scheduler.
package flp_mul_arb_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } state_e;

    function automatic int unsigned tag_width(input int unsigned nreq);
        return $clog2(nreq);
    endfunction

    function automatic int unsigned flp_width(input int unsigned ewidth, input int unsigned swidth);
        return 1 + ewidth + swidth;
    endfunction

endpackage

// File: rtl/flp_mul_arb_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module flp_mul_arb_rr #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned TAG_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [TAG_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [TAG_W-1:0] idx,
    output logic             any
);

    always_comb begin
        logic [TAG_W-1:0] k;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = TAG_W'((32'(ptr) + i) % NREQ);
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/flp_mul_arb.sv
// Round-robin scheduler sharing one fixed-latency pipelined FP multiplier among NREQ
// requesters, with tag tracking for response steering and a drain handshake.
module flp_mul_arb
    import flp_mul_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned EWIDTH  = 8,
    parameter int unsigned SWIDTH  = 23,
    parameter int unsigned RSWIDTH = 2,
    parameter int unsigned MUL_LAT = 3,
    localparam int unsigned W      = flp_width(EWIDTH, SWIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [NREQ*W-1:0] i_req_a,
    input  logic [NREQ*W-1:0] i_req_b,
    output logic [NREQ-1:0]   o_req_ready,
    output logic              o_mul_issue,
    output logic [W-1:0]      o_mul_a,
    output logic [W-1:0]      o_mul_b,
    input  logic [W-1:0]      i_mul_p,
    output logic [NREQ-1:0]   o_rsp_valid,
    output logic [W-1:0]      o_rsp_p,
    input  logic              i_drain,
    output logic              o_drained,
    output logic              o_busy
);

    localparam int unsigned TAG_W = tag_width(NREQ);

    if (NREQ < 2 || NREQ > 8 || MUL_LAT < 1 || RSWIDTH < 1) begin : g_param_check
        $error("flp_mul_arb: unsupported parameter combination");
    end

    state_e            state;
    logic [TAG_W-1:0]  rr_ptr;
    logic [TAG_W-1:0]  issue_tag;
    logic [MUL_LAT-1:0] tag_vld;
    logic [TAG_W-1:0]  tag_pipe [MUL_LAT];

    logic [W-1:0]      req_a_arr [NREQ];
    logic [W-1:0]      req_b_arr [NREQ];
    logic [NREQ-1:0]   gnt;
    logic [TAG_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic [TAG_W-1:0]  next_ptr;
    logic [NREQ-1:0]   rsp_onehot;

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign req_a_arr[k] = i_req_a[k*W +: W];
        assign req_b_arr[k] = i_req_b[k*W +: W];
    end

    flp_mul_arb_rr #(
        .NREQ  (NREQ),
        .TAG_W (TAG_W)
    ) u_rr (
        .req (i_req_valid & {NREQ{state == RUN}}),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign o_req_ready = gnt;
    assign next_ptr    = (gnt_idx == TAG_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign rsp_onehot  = NREQ'(1) << tag_pipe[MUL_LAT-1];
    // Response register is deliberately excluded: once a tag leaves the pipe it is done.
    assign o_busy      = o_mul_issue | (|tag_vld);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            o_mul_issue <= 1'b0;
            o_mul_a     <= '0;
            o_mul_b     <= '0;
            issue_tag   <= '0;
            tag_vld     <= '0;
            for (int i = 0; i < MUL_LAT; i++) tag_pipe[i] <= '0;
            o_rsp_valid <= '0;
            o_rsp_p     <= '0;
        end else begin
            o_mul_issue <= gnt_any;
            if (gnt_any) begin
                o_mul_a   <= req_a_arr[gnt_idx];
                o_mul_b   <= req_b_arr[gnt_idx];
                issue_tag <= gnt_idx;
                rr_ptr    <= next_ptr;
            end

            tag_vld[0]  <= o_mul_issue;
            tag_pipe[0] <= issue_tag;
            for (int i = MUL_LAT - 1; i > 0; i--) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end

            if (tag_vld[MUL_LAT-1]) begin
                o_rsp_valid <= rsp_onehot;
                o_rsp_p     <= i_mul_p;
            end else begin
                o_rsp_valid <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            o_drained <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (i_drain) state <= DRAIN;
                end
                DRAIN: begin
                    if (!i_drain) begin
                        state <= RUN;
                    end else if (!o_busy) begin
                        state     <= DRAINED;
                        o_drained <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!i_drain) begin
                        state     <= RUN;
                        o_drained <= 1'b0;
                    end
                end
                default: begin
                    state     <= RUN;
                    o_drained <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flp_mul_arb.sv
// Scoreboard bench for flp_mul_arb with a behavioural pipelined FP32 multiplier.
module tb_flp_mul_arb;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned W       = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ-1:0]   req_ready;
    logic              mul_issue;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [W-1:0]      mul_p;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_p;
    logic              drain = 1'b0;
    logic              drained;
    logic              busy;

    flp_mul_arb #(
        .NREQ    (NREQ),
        .EWIDTH  (8),
        .SWIDTH  (23),
        .RSWIDTH (2),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_req_ready (req_ready),
        .o_mul_issue (mul_issue),
        .o_mul_a     (mul_a),
        .o_mul_b     (mul_b),
        .i_mul_p     (mul_p),
        .o_rsp_valid (rsp_valid),
        .o_rsp_p     (rsp_p),
        .i_drain     (drain),
        .o_drained   (drained),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // Normal-operand FP32 multiply, truncating; only used as the external multiplier.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [9:0]  e;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (m[47]) begin
            e = e + 10'd1;
            return {s, e[7:0], m[46:24]};
        end
        return {s, e[7:0], m[45:23]};
    endfunction

    logic [31:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        mpipe[0] <= fmul(mul_a, mul_b);
        for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_p = mpipe[MUL_LAT-1];

    typedef struct {
        int          idx;
        logic [31:0] p;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] op_a  [NREQ];
    logic [31:0] op_b  [NREQ];
    logic [31:0] exp_p [NREQ];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response strobe appears.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'd1 << e.idx);
                    check("rsp_p", rsp_p, e.p);
                    check("rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                check("missing_rsp", 32'd0, 32'd1 << e.idx);
            end
        end
    end

    task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ-1:0] exp_rdy);
        @(negedge clk);
        req_valid = v;
        for (int k = 0; k < NREQ; k++) begin
            req_a[k*W +: W] = op_a[k];
            req_b[k*W +: W] = op_b[k];
        end
        #1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        for (int k = 0; k < NREQ; k++)
            if (exp_rdy[k] && v[k]) sb.push_back('{k, exp_p[k], cyc + MUL_LAT + 2});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        drain     = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic was_idle;
        logic got;
        for (int k = 0; k < NREQ; k++) begin
            op_a[k]  = 32'h0;
            op_b[k]  = 32'h0;
            exp_p[k] = 32'h0;
        end

        // Reset values
        do_reset();
        #1;
        check("rst_issue", 32'(mul_issue), 32'd0);
        check("rst_mul_a", mul_a, 32'd0);
        check("rst_mul_b", mul_b, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_p", rsp_p, 32'd0);
        check("rst_drained", 32'(drained), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single request: 2.0 * 4.0 = 8.0
        op_a[0] = 32'h40000000; op_b[0] = 32'h40800000; exp_p[0] = 32'h41000000;
        drive(4'b0001, 4'b0001);
        drive(4'b0000, 4'b0000);
        check("issue_plus1", 32'(mul_issue), 32'd1);
        check("mul_a_plus1", mul_a, 32'h40000000);
        check("mul_b_plus1", mul_b, 32'h40800000);
        drive(4'b0000, 4'b0000);
        check("issue_plus2", 32'(mul_issue), 32'd0);
        idle(6);

        // All four requesters valid: fairness and steering
        do_reset();
        op_a[0] = 32'h40000000; op_b[0] = 32'h3f800000; exp_p[0] = 32'h40000000;
        op_a[1] = 32'h40000000; op_b[1] = 32'h40000000; exp_p[1] = 32'h40800000;
        op_a[2] = 32'h40000000; op_b[2] = 32'h40400000; exp_p[2] = 32'h40c00000;
        op_a[3] = 32'h40000000; op_b[3] = 32'h40800000; exp_p[3] = 32'h41000000;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NREQ; k++) drive(4'hf, 4'b0001 << k);
        idle(7);

        // Mixed operands back-to-back
        do_reset();
        op_a[1] = 32'h405d2f1b; op_b[1] = 32'h3fe4fdf4; exp_p[1] = 32'h40c5d95e;
        op_a[3] = 32'h40000000; op_b[3] = 32'h40800000; exp_p[3] = 32'h41000000;
        drive(4'b0010, 4'b0010);
        drive(4'b1000, 4'b1000);
        idle(7);

        // Drain after three grants, then resume from the saved pointer
        do_reset();
        op_a[1] = 32'h40000000; op_b[1] = 32'h40000000; exp_p[1] = 32'h40800000;
        drive(4'hf, 4'b0001);
        drive(4'hf, 4'b0010);
        drive(4'hf, 4'b0100);
        drain    = 1'b1;
        was_idle = 1'b0;
        got      = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            drive(4'hf, 4'b0000);
            if (drained) begin
                got = 1'b1;
            end else begin
                if (was_idle) check("drained_late", 32'(drained), 32'd1);
                was_idle = !busy;
            end
        end
        check("drained", 32'(got), 32'd1);
        check("busy_when_drained", 32'(busy), 32'd0);
        drain = 1'b0;
        drive(4'hf, 4'b1000);
        drive(4'b0000, 4'b0000);
        idle(7);

        // Reset with two operations in flight
        do_reset();
        drive(4'b0001, 4'b0001);
        drive(4'b0010, 4'b0010);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        sb.delete();
        #1;
        check("midrst_issue", 32'(mul_issue), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_mul_a", mul_a, 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(8);

        // Gapped requests from req2 only; busy must stay high through the burst
        do_reset();
        op_a[2] = 32'h40000000; op_b[2] = 32'h40400000; exp_p[2] = 32'h40c00000;
        drive(4'b0100, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            drive(4'b0000, 4'b0000);
            check("gap_busy_idle", 32'(busy), 32'd1);
            drive(4'b0100, 4'b0100);
            check("gap_busy_req", 32'(busy), 32'd1);
        end
        // Pointer sits at 3 after a grant to 2, so 3 beats 1
        op_a[1] = 32'h40000000; op_b[1] = 32'h40000000; exp_p[1] = 32'h40800000;
        op_a[3] = 32'h40000000; op_b[3] = 32'h40800000; exp_p[3] = 32'h41000000;
        drive(4'b1010, 4'b1000);
        drive(4'b0010, 4'b0010);
        idle(8);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
